// File: rtl/dma_tx_sm.sv
// Write-side DMA channel state machine: drains a buffered block to AHB or APB
// as a counted sequence of accesses, then hands the buffer back to the read side.
module dma_tx_sm #(
    parameter int CNT_W = 4
) (
    input  logic             hclk,
    input  logic             n_hreset,
    input  logic             xfer_start,
    input  logic             target_apb,
    input  logic             read_complete,
    input  logic [CNT_W-1:0] block_beats,
    input  logic             last_block,
    input  logic             abort,
    input  logic             hready,
    input  logic             ahb_grant,
    input  logic             pready,
    input  logic             double_clk,
    output logic             ahb_req,
    output logic             apb_sel,
    output logic             apb_enable,
    output logic             write_complete,
    output logic             xfer_done,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [4:0]       dma_write_state,
    output logic [4:0]       next_write_state
);

    localparam logic [4:0] W_IDLE          = 5'h00;
    localparam logic [4:0] W_WAIT_FOR_READ = 5'h01;
    localparam logic [4:0] W_AHB_MAIN      = 5'h02;
    localparam logic [4:0] W_AHB_ADDR      = 5'h03;
    localparam logic [4:0] W_AHB_DATA      = 5'h04;
    localparam logic [4:0] W_APB_MAIN      = 5'h05;
    localparam logic [4:0] W_APB_DATA      = 5'h06;
    localparam logic [4:0] W_APB_HOLD      = 5'h07;
    localparam logic [4:0] W_DONE_BLOCK    = 5'h08;
    localparam logic [4:0] W_FINISH        = 5'h09;

    logic [4:0]       state;
    logic [4:0]       next_state;
    logic [CNT_W-1:0] cnt;
    logic             count_two;
    logic             phase_done;
    logic             last_beat;
    logic             in_apb;
    logic             next_in_apb;

    // With double_clk the APB phase spans two hclk cycles; count_two marks the second.
    assign phase_done  = ~double_clk | count_two;
    assign last_beat   = (cnt == CNT_W'(1));
    assign in_apb      = (state == W_APB_MAIN) || (state == W_APB_DATA);
    assign next_in_apb = (next_state == W_APB_MAIN) || (next_state == W_APB_DATA);

    always_comb begin
        next_state = state;
        case (state)
            W_IDLE:
                if (xfer_start) next_state = W_WAIT_FOR_READ;
            W_WAIT_FOR_READ:
                if (abort)                    next_state = W_FINISH;
                else if (read_complete) begin
                    if (block_beats == '0)    next_state = W_DONE_BLOCK;
                    else if (target_apb)      next_state = W_APB_MAIN;
                    else                      next_state = W_AHB_MAIN;
                end
            W_AHB_MAIN:
                if (abort)                    next_state = W_FINISH;
                else if (ahb_grant && hready) next_state = W_AHB_ADDR;
            W_AHB_ADDR:
                if (hready) next_state = W_AHB_DATA;
            W_AHB_DATA:
                if (hready) begin
                    if (abort)                next_state = W_FINISH;
                    else if (last_beat)       next_state = W_DONE_BLOCK;
                    else                      next_state = W_AHB_MAIN;
                end
            W_APB_MAIN:
                if (abort)                    next_state = W_FINISH;
                else if (phase_done)          next_state = W_APB_DATA;
            W_APB_DATA:
                if (abort)                    next_state = W_FINISH;
                else if (pready && phase_done)
                    next_state = last_beat ? W_DONE_BLOCK : W_APB_HOLD;
            W_APB_HOLD:
                next_state = abort ? W_FINISH : W_APB_MAIN;
            W_DONE_BLOCK:
                next_state = (last_block || abort) ? W_FINISH : W_WAIT_FOR_READ;
            W_FINISH:
                next_state = W_IDLE;
            default:
                next_state = W_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge n_hreset) begin
        if (!n_hreset) begin
            state     <= W_IDLE;
            cnt       <= '0;
            count_two <= 1'b0;
        end else begin
            state <= next_state;

            if (in_apb && next_in_apb) count_two <= double_clk ? ~count_two : count_two;
            else                       count_two <= 1'b0;

            // Decrements saturate so a stray beat at zero cannot wrap the count.
            if (state == W_WAIT_FOR_READ && !abort && read_complete)
                cnt <= block_beats;
            else if (state == W_AHB_DATA && hready)
                cnt <= (cnt == '0) ? '0 : cnt - CNT_W'(1);
            else if (state == W_APB_DATA && !abort && pready && phase_done)
                cnt <= (cnt == '0) ? '0 : cnt - CNT_W'(1);
            else if (state == W_FINISH)
                cnt <= '0;
        end
    end

    assign ahb_req          = (state == W_AHB_MAIN);
    assign apb_sel          = (state == W_APB_MAIN) || (state == W_APB_DATA);
    assign apb_enable       = (state == W_APB_DATA);
    assign write_complete   = (state == W_DONE_BLOCK);
    assign xfer_done        = (state == W_FINISH);
    assign beat_cnt         = cnt;
    assign dma_write_state  = state;
    assign next_write_state = next_state;

endmodule

// File: tb/tb_dma_tx_sm.sv
// Bench for dma_tx_sm: directed scenarios plus random blocks checked against a
// per-block expected trace of (state, beat count) built from the block description.
module tb_dma_tx_sm;

    localparam int CNT_W = 4;

    logic             hclk = 1'b0;
    logic             n_hreset;
    logic             xfer_start, target_apb, read_complete, last_block, abort;
    logic             hready, ahb_grant, pready, double_clk;
    logic [CNT_W-1:0] block_beats;
    logic             ahb_req, apb_sel, apb_enable, write_complete, xfer_done;
    logic [CNT_W-1:0] beat_cnt;
    logic [4:0]       dma_write_state, next_write_state;

    int checks = 0;
    int errors = 0;

    logic [4:0]       exp_state_q[$];
    logic [CNT_W-1:0] exp_cnt_q[$];

    dma_tx_sm #(.CNT_W(CNT_W)) dut (
        .hclk(hclk), .n_hreset(n_hreset), .xfer_start(xfer_start),
        .target_apb(target_apb), .read_complete(read_complete),
        .block_beats(block_beats), .last_block(last_block), .abort(abort),
        .hready(hready), .ahb_grant(ahb_grant), .pready(pready),
        .double_clk(double_clk), .ahb_req(ahb_req), .apb_sel(apb_sel),
        .apb_enable(apb_enable), .write_complete(write_complete),
        .xfer_done(xfer_done), .beat_cnt(beat_cnt),
        .dma_write_state(dma_write_state), .next_write_state(next_write_state)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {ahb_req, apb_sel, apb_enable, write_complete, xfer_done} implied by a state code
    function automatic logic [4:0] outs_for(input logic [4:0] s);
        case (s)
            5'h02:   return 5'b10000;
            5'h05:   return 5'b01000;
            5'h06:   return 5'b01100;
            5'h08:   return 5'b00010;
            5'h09:   return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic push(input logic [4:0] s, input int c);
        exp_state_q.push_back(s);
        exp_cnt_q.push_back(CNT_W'(c));
    endtask

    task automatic check_now(input string tag, input logic [4:0] s, input int c);
        chk({tag, "_state"}, 32'(dma_write_state), 32'(s));
        chk({tag, "_cnt"}, 32'(beat_cnt), 32'(c));
        chk({tag, "_outs"}, 32'({ahb_req, apb_sel, apb_enable, write_complete, xfer_done}),
            32'(outs_for(s)));
    endtask

    // Expects to start in w_wait_for_read with xfer_start held high.
    task automatic run_block(input int n, input bit apb, input bit dbl, input bit last);
        int p;
        logic [4:0] s;
        logic [CNT_W-1:0] c;
        p = dbl ? 2 : 1;
        chk("blk_start", 32'(dma_write_state), 32'h01);
        read_complete = 1'b1; block_beats = CNT_W'(n); target_apb = apb;
        double_clk = dbl; last_block = last; hready = 1'b1; ahb_grant = 1'b1;
        pready = 1'b1; abort = 1'b0; xfer_start = 1'b1;
        for (int k = n; k >= 1; k--) begin
            if (apb) begin
                repeat (p) push(5'h05, k);
                repeat (p) push(5'h06, k);
                if (k > 1) push(5'h07, k - 1);
            end else begin
                push(5'h02, k); push(5'h03, k); push(5'h04, k);
            end
        end
        push(5'h08, 0);
        if (last) begin
            push(5'h09, 0);
            push(5'h00, 0);
        end
        push(5'h01, 0);
        while (exp_state_q.size() > 0) begin
            step();
            read_complete = 1'b0;
            s = exp_state_q.pop_front();
            c = exp_cnt_q.pop_front();
            check_now("blk", s, int'(c));
        end
    endtask

    initial begin
        n_hreset = 1'b0; xfer_start = 1'b0; target_apb = 1'b0; read_complete = 1'b0;
        block_beats = '0; last_block = 1'b0; abort = 1'b0; hready = 1'b1;
        ahb_grant = 1'b1; pready = 1'b1; double_clk = 1'b0;

        #12;
        check_now("reset", 5'h00, 0);
        n_hreset = 1'b1;
        step();
        check_now("idle_hold", 5'h00, 0);
        xfer_start = 1'b1;
        #1;
        chk("idle_next", 32'(next_write_state), 32'h01);
        step();
        check_now("to_wait", 5'h01, 0);

        run_block(3, 1'b0, 1'b0, 1'b0);
        run_block(2, 1'b1, 1'b0, 1'b1);
        run_block(1, 1'b1, 1'b1, 1'b0);

        // hready stall in the data phase
        read_complete = 1'b1; block_beats = 4'd1; target_apb = 1'b0; last_block = 1'b0;
        step(); read_complete = 1'b0;
        check_now("stall_main", 5'h02, 1);
        step(); check_now("stall_addr", 5'h03, 1);
        step(); check_now("stall_data", 5'h04, 1);
        hready = 1'b0;
        repeat (3) begin
            step(); check_now("stall_hold", 5'h04, 1);
        end
        hready = 1'b1;
        step(); check_now("stall_done", 5'h08, 0);
        step(); check_now("stall_wait", 5'h01, 0);

        // abort while granted in w_ahb_main
        read_complete = 1'b1; block_beats = 4'd2;
        step(); read_complete = 1'b0;
        check_now("abm_main", 5'h02, 2);
        abort = 1'b1;
        step(); abort = 1'b0;
        check_now("abm_finish", 5'h09, 2);
        step(); check_now("abm_idle", 5'h00, 0);
        step(); check_now("abm_wait", 5'h01, 0);

        // abort while waiting for read
        abort = 1'b1;
        step(); abort = 1'b0;
        check_now("abw_finish", 5'h09, 0);
        step(); check_now("abw_idle", 5'h00, 0);
        step(); check_now("abw_wait", 5'h01, 0);

        run_block(0, 1'b0, 1'b0, 1'b0);
        run_block(0, 1'b1, 1'b0, 1'b1);

        // asynchronous reset in w_apb_data
        read_complete = 1'b1; block_beats = 4'd2; target_apb = 1'b1; double_clk = 1'b0;
        last_block = 1'b0;
        step(); read_complete = 1'b0;
        check_now("rst_main", 5'h05, 2);
        step(); check_now("rst_data", 5'h06, 2);
        #2 n_hreset = 1'b0;
        #1 check_now("rst_async", 5'h00, 0);
        #3 n_hreset = 1'b1;
        #1 check_now("rst_release", 5'h00, 0);
        step(); check_now("rst_wait", 5'h01, 0);

        for (int i = 0; i < 40; i++) begin
            run_block(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
